seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits (1..8).
REQ-002 SHALL have parameter DATA_W, default 16: width of the unsigned binary input value (4..20).
REQ-003 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit stays lit (>=2).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: when 1, seg and an drive 0 for lit/enabled.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port value, input, DATA_W: unsigned binary value to display, e.g. temperature.
REQ-008 SHALL have port load, input, 1: one-cycle strobe requesting capture of value.
REQ-009 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-010 SHALL have port overflow, output, 1: high while the displayed value exceeds 10^NUM_DIGITS-1.
REQ-011 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a} of the currently enabled digit.
REQ-012 SHALL have port an, output, NUM_DIGITS: one-hot digit enables, bit 0 = least significant digit.

Function
REQ-013 SHALL implement FSM states IDLE, CONVERT, COMMIT; reset state IDLE.
REQ-014 SHALL, in IDLE with load=1, register value and enter CONVERT; busy SHALL go high on that same edge.
REQ-015 SHALL ignore load asserted in CONVERT or COMMIT; no queuing.
REQ-016 SHALL perform sequential double-dabble in CONVERT, exactly one shift/add-3 step per clock, for DATA_W clocks, then enter COMMIT.
REQ-017 SHALL, in COMMIT, copy BCD digits 0..NUM_DIGITS-1 into the display register, update overflow, clear busy, and return to IDLE, all on one edge DATA_W+1 cycles after the load edge.
REQ-018 SHALL set overflow=1 when the captured value >= 10^NUM_DIGITS; every digit then shows a dash (segment g only).
REQ-019 SHALL leave display register and overflow unchanged while converting; the old value keeps being shown.
REQ-020 SHALL run a prescaler counting 0..SCAN_DIV-1 and wrapping; at terminal count the digit index SHALL advance by one, wrapping NUM_DIGITS-1 -> 0.
REQ-021 SHALL drive an one-hot at the digit index and seg with that digit's code, both registered and updated on the same edge (no cross-digit glitch).
REQ-022 SHALL encode digits 0-9 in standard 7-segment form (e.g. 0 = a-f lit, 1 = b,c lit); BCD codes 10-15 cannot occur and SHALL map to all-off.
REQ-023 SHALL invert seg and an when ACTIVE_LOW=1, including the all-off and dash codes.
REQ-024 SHALL keep the scan running independently of FSM state and load activity.

Reset
REQ-025 SHALL, while reset=1, asynchronously force FSM IDLE, busy=0, overflow=0, display register 0, prescaler 0, digit index 0, seg all-off, an all-disabled.
REQ-026 SHALL abort any conversion in progress on reset; no partial result SHALL be committed.
REQ-027 SHALL, on the first edge after reset release, enable digit 0 showing 0 (or blank per REQ-029).

Configuration
REQ-028 SHALL support macro BLANK_LEADING_ZEROS_EN.
REQ-029 SHALL, with BLANK_LEADING_ZEROS_EN defined, turn all segments off for every zero digit more significant than the highest non-zero digit; digit 0 is never blanked; no blanking during overflow.
REQ-030 SHALL, without BLANK_LEADING_ZEROS_EN, show all digits including leading zeros; blanking logic absent.

Verification
REQ-031 SHALL verify: reset, NUM_DIGITS=4, DATA_W=16, SCAN_DIV=4, load value=0x04D2 -> busy high 17 cycles, then digits 1,2,3,4 scanned 0->3, each held 4 cycles.
REQ-032 SHALL verify: load value=10000 -> overflow=1, all four digits show dash (seg=7'b0111111 with ACTIVE_LOW=1).
REQ-033 SHALL verify: second load 5 cycles after first -> ignored; first result displayed, busy falls at cycle 17.
REQ-034 SHALL verify: reset asserted at cycle 8 of conversion of 9999 -> outputs reset immediately; display shows 0 after release, never 9999.
REQ-035 SHALL verify: BLANK_LEADING_ZEROS_EN defined, load value=7 -> digits 3..1 all-off, digit 0 shows 7; undefined -> shows 0007.
REQ-036 SHALL verify: ACTIVE_LOW=0, value=8 -> enabled an bit high, digit 0 seg=7'b1111111.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: captures a binary value, converts it to BCD one double-dabble step
// per clock, and scans the digits. Optional macro: BLANK_LEADING_ZEROS_EN (blank leading zeros).
module seg_scan_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  // One spare BCD digit above what is needed so the overflow slice is never empty.
  localparam int unsigned MinBcd    = (DATA_W + 2) / 3;
  localparam int unsigned BcdDigits = ((MinBcd > NUM_DIGITS) ? MinBcd : NUM_DIGITS) + 1;
  localparam int unsigned BcdW      = 4 * BcdDigits;
  localparam int unsigned DispW     = 4 * NUM_DIGITS;
  localparam int unsigned CntW      = $clog2(DATA_W + 1);
  localparam int unsigned PreW      = $clog2(SCAN_DIV);
  localparam int unsigned DigW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0]            SegDash = 7'b1000000;
  localparam logic [6:0]            SegIdle = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AnIdle  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       bin_q, bin_d;
  logic [BcdW-1:0]         bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q, ovf_d;
  logic [DispW-1:0]        disp_q, disp_d;
  logic [PreW-1:0]         pre_q, pre_d;
  logic [DigW-1:0]         dig_q, dig_d;
  logic [6:0]              seg_q, seg_d, seg_raw;
  logic [NUM_DIGITS-1:0]   an_q, an_d, an_raw;
  logic [3:0]              cur_digit;
  logic                    blank;
`ifdef BLANK_LEADING_ZEROS_EN
  logic                    upper_zero;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BcdDigits); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StConvert;
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StConvert: begin
        bcd_d = {bcd_adj[BcdW-2:0], bin_q[DATA_W-1]};
        // The BCD carry-out is always zero; rotating it into the spent binary LSB is harmless.
        bin_d = {bin_q[DATA_W-2:0], bcd_adj[BcdW-1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(DATA_W - 1)) state_d = StCommit;
      end
      StCommit: begin
        disp_d  = bcd_q[DispW-1:0];
        ovf_d   = |bcd_q[BcdW-1:DispW];
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (pre_q == PreW'(SCAN_DIV - 1)) begin
      pre_d = '0;
      dig_d = (dig_q == DigW'(NUM_DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
      dig_d = dig_q;
    end
  end

  // Outputs are built from next-state values so an, seg and the display update on one edge.
  always_comb begin
    cur_digit = 4'd0;
    an_raw    = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (dig_d == DigW'(i)) begin
        cur_digit = disp_d[4*i +: 4];
        an_raw[i] = 1'b1;
      end
    end
    blank = 1'b0;
`ifdef BLANK_LEADING_ZEROS_EN
    upper_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (disp_d[4*i +: 4] == 4'd0);
      if (dig_d == DigW'(i)) blank = upper_zero;
    end
`endif
    if (ovf_d) begin
      seg_raw = SegDash;
    end else if (blank) begin
      seg_raw = 7'h00;
    end else begin
      seg_raw = seg_decode(cur_digit);
    end
    seg_d = ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = ACTIVE_LOW ? ~an_raw : an_raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
      pre_q   <= '0;
      dig_q   <= '0;
      seg_q   <= SegIdle;
      an_q    <= AnIdle;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      pre_q   <= pre_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed scenarios plus random loads/resets checked against a
// cycle-count model (decimal arithmetic for digits, elapsed cycles for scan position).
module tb_seg_scan_display;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int S  = 4;

  logic          clk;
  logic          reset;
  logic [DW-1:0] value;
  logic          load;
  logic          busy_lo, ovf_lo, busy_hi, ovf_hi;
  logic [6:0]    seg_lo, seg_hi;
  logic [N-1:0]  an_lo, an_hi;

  int checks   = 0;
  int failures = 0;

  // Model state
  int k;
  bit m_busy;
  int m_rem;
  int m_pend;
  int m_shown;
  bit m_ovf;
  bit m_in_reset;

  seg_scan_display #(.NUM_DIGITS(N), .DATA_W(DW), .SCAN_DIV(S), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy_lo), .overflow(ovf_lo), .seg(seg_lo), .an(an_lo)
  );

  seg_scan_display #(.NUM_DIGITS(N), .DATA_W(DW), .SCAN_DIV(S), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy_hi), .overflow(ovf_hi), .seg(seg_hi), .an(an_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int p10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r *= 10;
    return r;
  endfunction

  function automatic logic [6:0] digit_code(input int dg);
    case (dg)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg_raw(input int d);
    if (m_ovf) return 7'b1000000;
`ifdef BLANK_LEADING_ZEROS_EN
    if (d > 0 && m_shown < p10(d)) return 7'h00;
`endif
    return digit_code((m_shown / p10(d)) % 10);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [6:0]   sr, sr_n;
    logic [N-1:0] ar, ar_n;
    int d;
    if (m_in_reset) begin
      sr = 7'h00;
      ar = '0;
    end else begin
      d  = (k / S) % N;
      ar = '0;
      ar[d] = 1'b1;
      sr = exp_seg_raw(d);
    end
    sr_n = ~sr;
    ar_n = ~ar;
    check("busy", {31'b0, busy_lo}, {31'b0, m_busy});
    check("overflow", {31'b0, ovf_lo}, {31'b0, m_ovf});
    check("an_actlow", {28'b0, an_lo}, {28'b0, ar_n});
    check("seg_actlow", {25'b0, seg_lo}, {25'b0, sr_n});
    check("an_acthigh", {28'b0, an_hi}, {28'b0, ar});
    check("seg_acthigh", {25'b0, seg_hi}, {25'b0, sr});
  endtask

  task automatic model_reset();
    k          = 0;
    m_busy     = 1'b0;
    m_rem      = 0;
    m_shown    = 0;
    m_ovf      = 1'b0;
    m_in_reset = 1'b1;
  endtask

  task automatic tick();
    bit r = reset;
    bit l = load;
    int v = int'(value);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      k++;
      m_in_reset = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy  = 1'b0;
          m_shown = m_pend;
          m_ovf   = (m_pend >= p10(N));
        end
      end else if (l) begin
        m_busy = 1'b1;
        m_pend = v;
        m_rem  = DW + 1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input int v);
    value = DW'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Asserted between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset(input int hold);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    run(hold);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    model_reset();
    #2;
    check_all();
    run(2);
    reset = 1'b0;
    run(3);

    do_load(16'h04D2);
    run(40);

    do_load(10000);
    run(34);

    do_load(1234);
    run(4);
    do_load(4321);
    run(30);

    do_load(9999);
    run(7);
    do_reset(2);
    run(30);

    do_load(7);
    run(34);
    do_load(8);
    run(34);
    do_load(0);
    run(20);
    do_load(65535);
    run(20);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: value = DW'($urandom_range(0, 99));
          1: value = DW'($urandom_range(0, 9999));
          default: value = DW'($urandom_range(0, 65535));
        endcase
        load = 1'b1;
        tick();
        load = 1'b0;
      end else begin
        value = DW'($urandom);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
